// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared types, defaults and helpers for the banked SRAM buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

  localparam int c_def_dw      = 64;
  localparam int c_def_nbank   = 4;
  localparam int c_def_bank_aw = 12;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } sram_state_t;

  // One byte enable becomes eight active-low bit write enables.
  function automatic logic [7:0] byte_bwen(input logic en);
    return {8{~en}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_bank.sv
// ============================================================================
// Module      : sram_bank
// Description : One SRAM bank, active-low CEN/GWEN and active-low bit mask.
//               Behavioural array by default (SIM); SRAM_TECH_MACRO selects
//               the technology macro with test/retention pins tied off.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bank #(
  parameter int DW = 64,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          gwen,
  input  logic [DW-1:0] bwen,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

`ifdef SRAM_TECH_MACRO
  sram_sp_macro #(
    .DW (DW),
    .AW (AW)
  ) u_macro (
    .CLK  (clk),
    .CEN  (cen),
    .GWEN (gwen),
    .WEN  (bwen),
    .A    (addr),
    .D    (wdata),
    .Q    (rdata),
    .TEN  (1'b1),
    .RET  (1'b0),
    .EMA  (3'b010)
  );
`else
  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rdata;

  // Output latch only moves on a read; writes leave it untouched like the macro.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!gwen) begin
        r_mem[addr] <= (r_mem[addr] & bwen) | (wdata & ~bwen);
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;
`endif

endmodule

`default_nettype wire

// File: rtl/sram_banked_top.sv
// ============================================================================
// Module      : sram_banked_top
// Description : NBANK SRAM banks behind a valid/ready port with byte-masked
//               writes, fixed-latency reads and a zero-fill clear engine.
//               SRAM_OUT_REG_EN adds an output flop stage (2-cycle reads).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_banked_top
  import sram_pkg::*;
#(
  parameter int DW      = c_def_dw,
  parameter int NBANK   = c_def_nbank,
  parameter int BANK_AW = c_def_bank_aw,
  parameter int MW      = DW / 8,
  parameter int AW      = BANK_AW + $clog2(NBANK)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [MW-1:0] req_wem,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  input  logic          clr_start,
  output logic          init_done
);

  localparam int                 c_bsw      = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [BANK_AW-1:0] c_last_row = '1;

  sram_state_t        r_state, w_state_nxt;
  logic [BANK_AW-1:0] r_cnt, w_cnt_nxt;
  logic               w_accept, w_rd_accept;
  logic [c_bsw-1:0]   w_bank, r_rd_bank;
  logic [BANK_AW-1:0] w_row;
  logic [DW-1:0]      w_bwen;
  logic               r_rd_valid;
  logic [DW-1:0]      w_bank_q [NBANK];
  logic [DW-1:0]      w_rd_mux;

  assign req_ready   = (r_state == ST_RUN) && !clr_start;
  assign init_done   = (r_state == ST_RUN);
  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_we;
  assign w_row       = req_addr[BANK_AW-1:0];

  if (NBANK > 1) begin : g_bank_dec
    assign w_bank = req_addr[AW-1:BANK_AW];
  end else begin : g_bank_single
    assign w_bank = '0;
  end

  always_comb begin
    w_bwen = '1;
    for (int i = 0; i < MW; i++) begin
      w_bwen[8*i +: 8] = byte_bwen(req_wem[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter wraps to zero on its last clear write, ready for the next clear.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + BANK_AW'(1);
        if (r_cnt == c_last_row) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clr_start) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    logic               w_cs;
    logic               w_cen;
    logic               w_gwen;
    logic [DW-1:0]      w_bank_bwen;
    logic [DW-1:0]      w_wdata;
    logic [BANK_AW-1:0] w_addr;

    assign w_cs = w_accept && (w_bank == c_bsw'(g));

    always_comb begin
      if (r_state == ST_CLEAR) begin
        w_cen       = 1'b0;
        w_gwen      = 1'b0;
        w_bank_bwen = '0;
        w_addr      = r_cnt;
        w_wdata     = '0;
      end else begin
        w_cen       = ~w_cs;
        w_gwen      = ~req_we;
        w_bank_bwen = w_bwen;
        w_addr      = w_row;
        w_wdata     = req_wdata;
      end
    end

    sram_bank #(
      .DW (DW),
      .AW (BANK_AW)
    ) u_bank (
      .clk   (clk),
      .cen   (w_cen),
      .gwen  (w_gwen),
      .bwen  (w_bank_bwen),
      .addr  (w_addr),
      .wdata (w_wdata),
      .rdata (w_bank_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_bank  <= '0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_bank <= w_bank;
      end
    end
  end

  assign w_rd_mux = w_bank_q[r_rd_bank];

`ifdef SRAM_OUT_REG_EN
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= r_rd_valid;
      if (r_rd_valid) begin
        r_rsp_rdata <= w_rd_mux;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
`else
  logic [DW-1:0] r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (r_rd_valid) begin
      r_hold <= w_rd_mux;
    end
  end

  assign rsp_valid = r_rd_valid;
  assign rsp_rdata = r_rd_valid ? w_rd_mux : r_hold;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_banked_top.sv
// ============================================================================
// Module      : tb_sram_banked_top
// Description : Self-checking bench for sram_banked_top against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_banked_top;

  localparam int DW      = 64;
  localparam int NBANK   = 4;
  localparam int BANK_AW = 4;
  localparam int MW      = DW / 8;
  localparam int AW      = 6;
  localparam int DEPTH   = 16;
  localparam int NWORDS  = 64;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we    = 1'b0;
  logic [MW-1:0] req_wem   = '0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          clr_start = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] model [NWORDS];

  always #5 clk = ~clk;

  sram_banked_top #(
    .DW      (DW),
    .NBANK   (NBANK),
    .BANK_AW (BANK_AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_wem   (req_wem),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .clr_start (clr_start),
    .init_done (init_done)
  );

  task automatic model_write(input logic [AW-1:0] a, input logic [MW-1:0] m,
                             input logic [DW-1:0] d);
    for (int b = 0; b < MW; b++) begin
      if (m[b]) model[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NWORDS; i++) model[i] = '0;
  endtask

  // One clock: drive at the falling edge, capture at the next falling edge.
  task automatic step(input logic v, input logic we, input logic [MW-1:0] m,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic clr,
                      output logic acc, output logic rv, output logic [DW-1:0] rd,
                      output logic id);
    req_valid = v; req_we = we; req_wem = m; req_addr = a; req_wdata = d; clr_start = clr;
    #1;
    acc = v && req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0; clr_start = 1'b0;
    @(negedge clk);
    rv = rsp_valid; rd = rsp_rdata; id = init_done;
  endtask

  task automatic test_reset();
    logic acc, rv, id;
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, init_done} !== 3'b000 || rsp_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready=%b valid=%b done=%b rdata=%h, expected all 0",
               req_ready, rsp_valid, init_done, rsp_rdata);
    end
    rst_n = 1'b1;
    n = 0; id = 1'b0;
    while (!id && n < 40) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, rv, rd, id);
      n++;
    end
    n_cmp++;
    if (n !== DEPTH) begin
      n_bad++;
      $display("FAIL init_latency: got %0d cycles, expected %0d", n, DEPTH);
    end
    model_clear();
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 6'h00 : 6'h3F;
      step(1'b1, 1'b0, '0, a, '0, 1'b0, acc, rv, rd, id);
      repeat (LAT - 1) step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, rv, rd, id);
      n_cmp++;
      if (rv !== 1'b1 || rd !== 64'h0) begin
        n_bad++;
        $display("FAIL post_init_read[%h]: got valid=%b data=%h, expected valid=1 data=0",
                 a, rv, rd);
      end
    end
  endtask

  task automatic test_byte_mask();
    logic acc, rv, id;
    logic [DW-1:0] rd;
    logic rv_w0, rv_w1;
    step(1'b1, 1'b1, 8'hFF, 6'h25, 64'hDEADBEEF_CAFEF00D, 1'b0, acc, rv_w0, rd, id);
    model_write(6'h25, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    step(1'b1, 1'b1, 8'h0F, 6'h25, 64'h11111111_22222222, 1'b0, acc, rv_w1, rd, id);
    model_write(6'h25, 8'h0F, 64'h11111111_22222222);
    n_cmp++;
    if (rv_w0 !== 1'b0 || rv_w1 !== 1'b0) begin
      n_bad++;
      $display("FAIL write_no_rsp: got valid=%b,%b, expected 0,0", rv_w0, rv_w1);
    end
    step(1'b1, 1'b0, '0, 6'h25, '0, 1'b0, acc, rv, rd, id);
    repeat (LAT - 1) step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, rv, rd, id);
    n_cmp++;
    if (rv !== 1'b1 || rd !== 64'hDEADBEEF_22222222) begin
      n_bad++;
      $display("FAIL byte_mask_raw: got valid=%b data=%h, expected 1 deadbeef22222222", rv, rd);
    end
    // Zero mask must be accepted and leave the word alone.
    step(1'b1, 1'b1, 8'h00, 6'h25, 64'hFFFFFFFF_FFFFFFFF, 1'b0, acc, rv, rd, id);
    n_cmp++;
    if (acc !== 1'b1) begin
      n_bad++;
      $display("FAIL wem0_accept: got ready=%b, expected 1", acc);
    end
    step(1'b1, 1'b0, '0, 6'h25, '0, 1'b0, acc, rv, rd, id);
    repeat (LAT - 1) step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, rv, rd, id);
    n_cmp++;
    if (rv !== 1'b1 || rd !== model[6'h25]) begin
      n_bad++;
      $display("FAIL wem0_noop: got valid=%b data=%h, expected 1 %h", rv, rd, model[6'h25]);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, rv, id;
    logic [DW-1:0] rd;
    logic          lv [8];
    logic [DW-1:0] ld [8];
    logic [AW-1:0] a;
    for (int k = 0; k < 4; k++) begin
      a = AW'(16 * k + 5);
      step(1'b1, 1'b1, 8'hFF, a, DW'(k + 1), 1'b0, acc, rv, rd, id);
      model_write(a, 8'hFF, DW'(k + 1));
    end
    for (int j = 0; j < 4 + LAT; j++) begin
      a = AW'(16 * j + 5);
      step(j < 4, 1'b0, '0, a, '0, 1'b0, acc, lv[j], ld[j], id);
    end
    for (int j = 0; j < 4 + LAT; j++) begin
      n_cmp++;
      if (j >= LAT - 1 && j <= LAT + 2) begin
        if (lv[j] !== 1'b1 || ld[j] !== model[AW'(16 * (j - LAT + 1) + 5)]) begin
          n_bad++;
          $display("FAIL b2b_rsp[%0d]: got valid=%b data=%h, expected 1 %h", j, lv[j], ld[j],
                   model[AW'(16 * (j - LAT + 1) + 5)]);
        end
      end else if (lv[j] !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_idle[%0d]: got valid=%b, expected 0", j, lv[j]);
      end
    end
    n_cmp++;
    if (ld[3 + LAT] !== model[6'h35]) begin
      n_bad++;
      $display("FAIL b2b_hold: got %h, expected %h", ld[3 + LAT], model[6'h35]);
    end
  endtask

  task automatic test_clear_collision();
    logic acc, id, acc1;
    logic          lv [2];
    logic [DW-1:0] ld [2];
    logic [DW-1:0] rd, pre;
    logic rv;
    int zeros, extra, guard;
    pre = model[6'h15];
    step(1'b1, 1'b0, '0, 6'h15, '0, 1'b0, acc, lv[0], ld[0], id);
    step(1'b1, 1'b0, '0, 6'h15, '0, 1'b1, acc1, lv[1], ld[1], id);
    n_cmp++;
    if (acc1 !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_priority: got ready=%b, expected 0", acc1);
    end
    n_cmp++;
    if (lv[LAT - 1] !== 1'b1 || ld[LAT - 1] !== pre || lv[2 - LAT] !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_clear_read: got valid=%b data=%h other=%b, expected 1 %h 0",
               lv[LAT - 1], ld[LAT - 1], lv[2 - LAT], pre);
    end
    zeros = id ? 0 : 1; extra = 0; guard = 0;
    while (!id && guard < 40) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, rv, rd, id);
      if (!id) zeros++;
      if (rv) extra++;
      guard++;
    end
    model_clear();
    n_cmp++;
    if (zeros !== DEPTH || extra !== 0) begin
      n_bad++;
      $display("FAIL clear_duration: got %0d cycles low, %0d stray rsp, expected %0d, 0",
               zeros, extra, DEPTH);
    end
    step(1'b1, 1'b0, '0, 6'h15, '0, 1'b0, acc, rv, rd, id);
    repeat (LAT - 1) step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, rv, rd, id);
    n_cmp++;
    if (rv !== 1'b1 || rd !== model[6'h15]) begin
      n_bad++;
      $display("FAIL post_clear_read: got valid=%b data=%h, expected 1 %h", rv, rd, model[6'h15]);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic acc, rv, id;
    logic [DW-1:0] rd, v;
    int n;
    v = {$urandom, $urandom} | 64'h1;
    step(1'b1, 1'b1, 8'hFF, 6'h2A, v, 1'b0, acc, rv, rd, id);
    model_write(6'h2A, 8'hFF, v);
    step(1'b1, 1'b0, '0, 6'h2A, '0, 1'b0, acc, rv, rd, id);
    repeat (LAT - 1) step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, rv, rd, id);
    n_cmp++;
    if (rv !== 1'b1 || rd !== model[6'h2A]) begin
      n_bad++;
      $display("FAIL prereset_read: got valid=%b data=%h, expected 1 %h", rv, rd, model[6'h2A]);
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, rv, rd, id);
    repeat (7) step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, rv, rd, id);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, init_done} !== 3'b000 || rsp_rdata !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got ready=%b valid=%b done=%b rdata=%h, expected all 0",
               req_ready, rsp_valid, init_done, rsp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; id = 1'b0;
    while (!id && n < 40) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, rv, rd, id);
      n++;
    end
    model_clear();
    n_cmp++;
    if (n !== DEPTH) begin
      n_bad++;
      $display("FAIL restart_latency: got %0d cycles, expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_random();
    localparam int N = 300;
    logic acc, rv, id, v, we;
    logic [DW-1:0] rd, d, e, last;
    logic [MW-1:0] m;
    logic [AW-1:0] a, prev;
    logic [DW-1:0] exp_q [$];
    int            due_q [$];
    last = '0; prev = '0;
    for (int s = 0; s < N + LAT; s++) begin
      v  = (s < N);
      we = 1'($urandom);
      m  = MW'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? prev : AW'($urandom);
      d  = {$urandom, $urandom};
      prev = a;
      step(v, we, m, a, d, 1'b0, acc, rv, rd, id);
      if (v) begin
        n_cmp++;
        if (acc !== 1'b1) begin
          n_bad++;
          $display("FAIL rand_ready[%0d]: got %b, expected 1", s, acc);
        end
        if (we) begin
          model_write(a, m, d);
        end else begin
          exp_q.push_back(model[a]);
          due_q.push_back(s + LAT - 1);
        end
      end
      n_cmp++;
      if (due_q.size() > 0 && due_q[0] == s) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        last = e;
        if (rv !== 1'b1 || rd !== e) begin
          n_bad++;
          $display("FAIL rand_rsp[%0d]: got valid=%b data=%h, expected 1 %h", s, rv, rd, e);
        end
      end else if (rv !== 1'b0 || rd !== last) begin
        n_bad++;
        $display("FAIL rand_idle[%0d]: got valid=%b data=%h, expected 0 %h", s, rv, rd, last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_mask();
    test_back_to_back();
    test_clear_collision();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
